fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- PC/fetch stage of the single-cycle RV32 core; sits directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM word address; ROM returns the instruction combinationally in the same cycle.
- Forwards instruction, PC and PC+4 to decode/execute, and applies branch/jump redirects.
- Detects the halt word and illegal fetch addresses, and freezes the core.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
- ADDR_W, 5, ROM word-address width; ROM depth is 2**ADDR_W words
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]
- rom_instr  in  32  ROM data for rom_addr, same cycle
- stall  in  1  hold PC this cycle
- redirect_valid  in  1  take redirect_target as next PC (branch taken/JAL/JALR)
- redirect_target  in  32  byte address of redirect
- instr  out  32  instruction to decode (= rom_instr)
- instr_valid  out  1  instr may be executed/committed this cycle
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, modulo 2**32, for JAL/JALR link
- halted  out  1  halt word reached; sticky
- fault  out  1  misaligned or out-of-range fetch; sticky
- fault_addr  out  32  offending address captured at fault
- fetch_count  out  32  committed-fetch counter (see Optional Feature)

Behaviour:
- States: RUN, HALT, FAULT. Reset → RUN, pc=RESET_PC, halted=0, fault=0, fault_addr=0, fetch_count=0.
- Combinational outputs: rom_addr, instr, pc_plus4.
- instr_valid = (state==RUN) & (rom_instr != HALT_WORD) & in_range(pc).
- in_range(pc): pc[1:0]==0 and pc[31:ADDR_W+2]==0.
- RUN, per rising edge, in priority order:
  1. rom_instr==HALT_WORD → HALT; pc held; redirect/stall ignored.
  2. !in_range(pc) → FAULT; fault_addr<=pc; pc held.
  3. stall → pc held.
  4. redirect_valid with redirect_target[1:0]!=0 → FAULT; fault_addr<=redirect_target; pc held.
  5. redirect_valid → pc<=redirect_target. Out-of-range targets are accepted here and fault on the next cycle via rule 2.
  6. Otherwise pc<=pc+4. Wrap at 2**32 is modular and faults via rule 2.
- HALT: pc frozen, instr_valid=0, halted=1. Only reset exits.
- FAULT: pc frozen, instr_valid=0, fault=1, fault_addr stable. Only reset exits.
- halted and fault are registered: they assert the cycle after the triggering edge and are never both 1.
- Latency: redirect seen at edge N → new PC visible on pc/rom_addr after edge N; zero bubbles.
- Reset asserted mid-operation, in any state, overrides everything on that edge.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: fetch_count increments by 1 on every edge where instr_valid & !stall, saturating at 32'hFFFF_FFFF; cleared by reset; frozen in HALT/FAULT.
- Undefined: no counter register; fetch_count tied to 0.

Decomposition:
- Shared package core_pkg holds:
  - fetch state encoding (RUN=2'd0, HALT=2'd1, FAULT=2'd2)
  - HALT_WORD constant
  - INSTR_BYTES=4
  - XLEN=32
- One natural sub-module, pc_next_sel: combinational priority logic producing next_pc and next_state. fetch_unit keeps all registers.

Test Plan:
- Reset release, ROM word0=0x00200513 → cycle0 pc=0, rom_addr=0, instr_valid=1; after edge pc=4, rom_addr=1, pc_plus4=8.
- Stall high 3 cycles at pc=8 → pc stays 8 for 3 edges, then advances to 0xC.
- redirect_valid=1, target=0x10 at pc=4 → next pc=0x10, rom_addr=4; concurrent stall=1 instead → pc held at 4, redirect dropped.
- Reach pc=0xC with ROM word3=0xFFFFFFFF → instr_valid=0 that cycle; halted=1 after edge; pc stays 0xC for 10 further cycles despite redirect pulses.
- redirect_target=0x12 → fault=1, fault_addr=0x12, pc unchanged; separately target=0x80 (ADDR_W=5) → accepted, fault next cycle with fault_addr=0x80.
- FETCH_PERF_EN defined, run words 0..2 then halt → fetch_count=3 and frozen; macro undefined → fetch_count=0 throughout; reset asserted during HALT → pc=0, halted=0 next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and constants for the RV32 pipeline.
// Fetch state encoding and instruction-word constants live here.
package core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC / next-state priority logic for the fetch stage.
// Purely combinational; all state is held by fetch_unit.
module pc_next_sel #(
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] HALT_WORD = core_pkg::HALT_WORD
) (
  input  core_pkg::fetch_state_e i_state,
  input  logic [31:0]            i_pc,
  input  logic [31:0]            i_rom_instr,
  input  logic                   i_stall,
  input  logic                   i_redirect_valid,
  input  logic [31:0]            i_redirect_target,
  input  logic [31:0]            i_fault_addr,
  output logic                   o_instr_valid,
  output logic [31:0]            o_next_pc,
  output logic [31:0]            o_next_fault_addr,
  output core_pkg::fetch_state_e o_next_state
);
  import core_pkg::*;

  logic w_run;
  logic w_halt_hit;
  logic w_in_range;
  logic w_tgt_mis;

  assign w_run      = (i_state == RUN);
  assign w_halt_hit = (i_rom_instr == HALT_WORD);
  assign w_in_range = (i_pc[1:0] == 2'b00) &&
                      ((i_pc >> (ADDR_W + 2)) == '0);
  assign w_tgt_mis  = (i_redirect_target[1:0] != 2'b00);

  assign o_instr_valid = w_run & ~w_halt_hit & w_in_range;

  // Halt beats every other cause; only RUN can leave its state.
  always_comb begin
    o_next_pc         = i_pc;
    o_next_state      = i_state;
    o_next_fault_addr = i_fault_addr;
    if (w_run) begin
      if (w_halt_hit) begin
        o_next_state = HALT;
      end else if (!w_in_range) begin
        o_next_state      = FAULT;
        o_next_fault_addr = i_pc;
      end else if (i_stall) begin
        o_next_pc = i_pc;
      end else if (i_redirect_valid && w_tgt_mis) begin
        o_next_state      = FAULT;
        o_next_fault_addr = i_redirect_target;
      end else if (i_redirect_valid) begin
        o_next_pc = i_redirect_target;
      end else begin
        o_next_pc = i_pc + 32'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage: PC register, ROM addressing, redirect, halt/fault.
// Define FETCH_PERF_EN to build the committed-fetch counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] HALT_WORD = core_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fault_addr,
  output logic [31:0]       fetch_count
);
  import core_pkg::*;

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_fault_addr;
  logic         r_halted;
  logic         r_fault;

  fetch_state_e w_next_state;
  logic [31:0]  w_next_pc;
  logic [31:0]  w_next_fault_addr;
  logic         w_instr_valid;

  pc_next_sel #(
    .ADDR_W    (ADDR_W),
    .HALT_WORD (HALT_WORD)
  ) u_sel (
    .i_state           (r_state),
    .i_pc              (r_pc),
    .i_rom_instr       (rom_instr),
    .i_stall           (stall),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_fault_addr      (r_fault_addr),
    .o_instr_valid     (w_instr_valid),
    .o_next_pc         (w_next_pc),
    .o_next_fault_addr (w_next_fault_addr),
    .o_next_state      (w_next_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_fault_addr <= '0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_fault_addr <= w_next_fault_addr;
      r_halted     <= (w_next_state == HALT);
      r_fault      <= (w_next_state == FAULT);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_instr_valid && !stall && r_count != '1) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign fetch_count = r_count;
`else
  assign fetch_count = '0;
`endif

  assign rom_addr    = r_pc[ADDR_W+1:2];
  assign instr       = rom_instr;
  assign instr_valid = w_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'(INSTR_BYTES);
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus
// randomized runs against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  logic [31:0] rom [32];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_fa;
  logic [31:0] m_cnt;
  bit          m_halt;
  bit          m_fault;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .rom_addr        (rom_addr),
    .rom_instr       (rom_instr),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .halted          (halted),
    .fault           (fault),
    .fault_addr      (fault_addr),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb rom_instr = rom[rom_addr];

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    return rom[(m_pc >> 2) % 32];
  endfunction

  function automatic bit m_inr(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd128);
  endfunction

  function automatic bit m_valid();
    return !m_halt && !m_fault &&
           m_word() != HW && m_inr(m_pc);
  endfunction

  task automatic check_all();
    logic [31:0] exp_cnt;
`ifdef FETCH_PERF_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    chk("pc", pc, m_pc);
    chk("rom_addr", 32'(rom_addr), (m_pc >> 2) % 32);
    chk("instr", instr, m_word());
    chk("instr_valid", 32'(instr_valid), 32'(m_valid()));
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_addr", fault_addr, m_fa);
    chk("fetch_count", fetch_count, exp_cnt);
  endtask

  task automatic model_edge(input bit r, input bit s,
                            input bit rv, input logic [31:0] t);
    if (r) begin
      m_pc = 32'd0; m_fa = 32'd0; m_cnt = 32'd0;
      m_halt = 0; m_fault = 0;
    end else if (!m_halt && !m_fault) begin
`ifdef FETCH_PERF_EN
      if (m_valid() && !s && m_cnt != 32'hFFFF_FFFF)
        m_cnt = m_cnt + 1;
`endif
      if (m_word() == HW) m_halt = 1;
      else if (!m_inr(m_pc)) begin m_fault = 1; m_fa = m_pc; end
      else if (s) ;
      else if (rv && t % 4 != 0) begin m_fault = 1; m_fa = t; end
      else if (rv) m_pc = t;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  // Drive one cycle of inputs, check, then advance past the edge.
  task automatic step(input bit r, input bit s,
                      input bit rv, input logic [31:0] t);
    reset = r; stall = s;
    redirect_valid = rv; redirect_target = t;
    #1;
    if (!r) check_all();
    model_edge(r, s, rv, t);
    @(posedge clk);
    #1;
    reset = 0; stall = 0; redirect_valid = 0;
  endtask

  task automatic load_rom(input bit halt3);
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013;
    rom[0] = 32'h0020_0513;
    if (halt3) rom[3] = HW;
  endtask

  initial begin
    m_pc = 0; m_fa = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
    load_rom(1);
    @(posedge clk); #1;

    // reset release, sequential fetch, redirect vs stall
    step(1, 0, 0, 0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd1);
    chk("rst_instr", instr, 32'h0020_0513);
    step(0, 0, 0, 0);
    chk("seq_pc", pc, 32'd4);
    chk("seq_addr", 32'(rom_addr), 32'd1);
    chk("seq_p4", pc_plus4, 32'd8);
    step(0, 1, 1, 32'h10);
    chk("stall_redir_pc", pc, 32'd4);
    step(0, 0, 1, 32'h10);
    chk("redir_pc", pc, 32'h10);
    chk("redir_addr", 32'(rom_addr), 32'd4);

    // stall at 8, then run into the halt word at 0xC
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall_pc", pc, 32'd8);
    end
    step(0, 0, 0, 0);
    chk("pre_halt_pc", pc, 32'hC);
    chk("halt_word_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0);
    chk("halted", 32'(halted), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_count", fetch_count, 32'd3);
`else
    chk("perf_count_off", fetch_count, 32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      step(0, 0, i[0], 32'h14);
      chk("halt_hold_pc", pc, 32'hC);
    end
`ifdef FETCH_PERF_EN
    chk("perf_frozen", fetch_count, 32'd3);
`endif
    step(1, 0, 0, 0);
    chk("rst_halt_pc", pc, 32'd0);
    chk("rst_halt_flag", 32'(halted), 32'd0);

    // misaligned redirect, then out-of-range redirect
    step(0, 0, 1, 32'h12);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fa", fault_addr, 32'h12);
    chk("mis_pc", pc, 32'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h80);
    chk("oor_pc", pc, 32'h80);
    chk("oor_nofault", 32'(fault), 32'd0);
    step(0, 0, 0, 0);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_fa", fault_addr, 32'h80);

    // randomized episodes against the model
    for (int e = 0; e < 40; e++) begin
      for (int i = 0; i < 32; i++) begin
        rom[i] = ($urandom_range(0, 15) == 0) ? HW : $urandom;
        if (rom[i] == HW && i == 0) rom[i] = 32'h13;
      end
      step(1, 0, 0, 0);
      for (int c = 0; c < 60; c++) begin
        bit          s;
        bit          rv;
        logic [31:0] t;
        int          k;
        s  = ($urandom_range(0, 3) == 0);
        rv = ($urandom_range(0, 3) == 0);
        k  = $urandom_range(0, 9);
        if (k < 7) t = {25'd0, 5'($urandom), 2'b00};
        else if (k < 9) t = {25'd0, 7'($urandom)};
        else t = $urandom;
        step($urandom_range(0, 79) == 0, s, rv, t);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
